// File: rtl/quiz_pkg.sv
// quiz_pkg -- shared definitions for the hex quiz round sequencer.
//   * Game-state codes driven by the top-level game FSM.
//   * Round-state codes and enum for quiz_round_ctrl.
//   * Per-difficulty value mask, time limit and points.
//   * LFSR seed and feedback taps.
// Optional feature macro used by quiz_round_ctrl: QUIZ_STREAK_BONUS_EN.
package quiz_pkg;

  // Game FSM state codes seen on game_state.
  localparam logic [2:0] GS_MENU        = 3'd1;
  localparam logic [2:0] GS_TRY_AGAIN   = 3'd2;
  localparam logic [2:0] GS_EASY        = 3'd3;
  localparam logic [2:0] GS_MEDIUM      = 3'd4;
  localparam logic [2:0] GS_HARD        = 3'd5;
  localparam logic [2:0] GS_LEADERBOARD = 3'd6;

  // Round-state codes, kept as plain constants so the encoding stays fixed.
  localparam logic [2:0] RS_IDLE  = 3'd0;
  localparam logic [2:0] RS_LOAD  = 3'd1;
  localparam logic [2:0] RS_ASK   = 3'd2;
  localparam logic [2:0] RS_JUDGE = 3'd3;
  localparam logic [2:0] RS_DONE  = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE  = RS_IDLE,
    ST_LOAD  = RS_LOAD,
    ST_ASK   = RS_ASK,
    ST_JUDGE = RS_JUDGE,
    ST_DONE  = RS_DONE
  } round_state_e;

  typedef enum logic [1:0] {
    DIFF_EASY   = 2'd0,
    DIFF_MEDIUM = 2'd1,
    DIFF_HARD   = 2'd2
  } diff_e;

  // Per-difficulty parameters.
  localparam logic [7:0] MASK_EASY    = 8'h0F;
  localparam logic [7:0] MASK_MEDIUM  = 8'hFF;
  localparam logic [7:0] MASK_HARD    = 8'hFF;
  localparam logic [5:0] LIMIT_EASY   = 6'd30;
  localparam logic [5:0] LIMIT_MEDIUM = 6'd20;
  localparam logic [5:0] LIMIT_HARD   = 6'd10;
  localparam logic [7:0] POINTS_EASY   = 8'd1;
  localparam logic [7:0] POINTS_MEDIUM = 8'd2;
  localparam logic [7:0] POINTS_HARD   = 8'd3;

  typedef struct packed {
    logic [7:0] mask;
    logic [5:0] limit;
    logic [7:0] points;
  } diff_cfg_t;

  // LFSR constants.
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // Only called with game_state already known to be 3..5.
  function automatic diff_e gs_to_diff(input logic [2:0] gs);
    case (gs)
      GS_EASY:   return DIFF_EASY;
      GS_MEDIUM: return DIFF_MEDIUM;
      default:   return DIFF_HARD;
    endcase
  endfunction

  function automatic diff_cfg_t diff_cfg(input diff_e diff);
    diff_cfg_t cfg;
    case (diff)
      DIFF_EASY:   cfg = '{mask: MASK_EASY,   limit: LIMIT_EASY,   points: POINTS_EASY};
      DIFF_MEDIUM: cfg = '{mask: MASK_MEDIUM, limit: LIMIT_MEDIUM, points: POINTS_MEDIUM};
      default:     cfg = '{mask: MASK_HARD,   limit: LIMIT_HARD,   points: POINTS_HARD};
    endcase
    return cfg;
  endfunction

endpackage

// File: rtl/quiz_lfsr.sv
// quiz_lfsr -- free-running 16-bit Galois LFSR (taps 0xB400, seed 0xACE1).
// Ports:
//   clk    in   system clock
//   reset  in   synchronous active-high; reloads the seed
//   value  out  current 16-bit LFSR state
// A Galois LFSR seeded non-zero never reaches the all-zero state.
module quiz_lfsr
  import quiz_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  output logic [15:0] value
);

  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;

  // NOTE: every variable written in always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    lfsr_d = {1'b0, lfsr_q[15:1]};
    if (lfsr_q[0]) begin
      lfsr_d = lfsr_d ^ LFSR_TAPS;
    end
  end

  // NOTE: flops are written with non-blocking assignments so every register
  // samples its pre-edge inputs regardless of block ordering.
  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign value = lfsr_q;

endmodule

// File: rtl/quiz_round_ctrl.sv
// quiz_round_ctrl -- runs one round of NUM_Q hex questions for the quiz game.
// Parameters:
//   TICK_CYCLES  clk cycles per countdown second
//   NUM_Q        questions per round (1..15)
// Ports:
//   clk           in   system clock
//   reset         in   synchronous active-high, clears all state
//   game_state    in   game FSM state code (3/4/5 = easy/medium/hard)
//   submit        in   one-cycle answer strobe
//   answer        in   player's binary entry
//   question      out  hex value to display
//   q_index       out  current question number, 0-based
//   secs_left     out  seconds remaining for the current question
//   score         out  accumulated score, saturating at 255
//   last_correct  out  result of the most recently judged question
//   round_done    out  level, drives the game FSM 'rem' input
// Optional feature: define QUIZ_STREAK_BONUS_EN for a +1 bonus on every third
// consecutive correct answer.
module quiz_round_ctrl
  import quiz_pkg::*;
#(
  parameter int TICK_CYCLES = 50_000_000,
  parameter int NUM_Q       = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] game_state,
  input  logic       submit,
  input  logic [7:0] answer,
  output logic [7:0] question,
  output logic [3:0] q_index,
  output logic [5:0] secs_left,
  output logic [7:0] score,
  output logic       last_correct,
  output logic       round_done
);

  localparam int PRESC_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(TICK_CYCLES - 1);
  localparam logic [3:0] LAST_Q = 4'(NUM_Q - 1);

  round_state_e       state_q, state_d;
  diff_e              diff_q, diff_d;
  logic [7:0]         question_q, question_d;
  logic [3:0]         q_index_q, q_index_d;
  logic [5:0]         secs_left_q, secs_left_d;
  logic [7:0]         score_q, score_d;
  logic               last_correct_q, last_correct_d;
  logic               round_done_q, round_done_d;
  logic               correct_q, correct_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
`ifdef QUIZ_STREAK_BONUS_EN
  logic [1:0]         streak_q, streak_d;
`endif

  logic [15:0] lfsr_value;
  logic        lfsr_unused;
  diff_cfg_t   cfg;
  logic        gs_active;
  logic        tick;
  logic        go_idle;
  logic        bonus;
  logic [9:0]  score_sum;

  quiz_lfsr u_lfsr (
    .clk   (clk),
    .reset (reset),
    .value (lfsr_value)
  );

  // Only the low byte feeds the question; the rest is deliberately unused.
  assign lfsr_unused = ^lfsr_value[15:8];

  assign cfg       = diff_cfg(diff_q);
  assign gs_active = (game_state >= GS_EASY) && (game_state <= GS_HARD);
  assign tick      = (presc_q == PRESC_MAX);

  always_comb begin
    state_d        = state_q;
    diff_d         = diff_q;
    question_d     = question_q;
    q_index_d      = q_index_q;
    secs_left_d    = secs_left_q;
    score_d        = score_q;
    last_correct_d = last_correct_q;
    round_done_d   = round_done_q;
    correct_d      = correct_q;
    presc_d        = presc_q;
`ifdef QUIZ_STREAK_BONUS_EN
    streak_d       = streak_q;
`endif
    go_idle        = 1'b0;
    bonus          = 1'b0;
    score_sum      = '0;

    case (state_q)
      ST_IDLE: begin
        // Difficulty is captured here and held for the whole round.
        if (gs_active) begin
          diff_d  = gs_to_diff(game_state);
          state_d = ST_LOAD;
        end
      end

      ST_LOAD: begin
        question_d  = lfsr_value[7:0] & cfg.mask;
        secs_left_d = cfg.limit;
        presc_d     = '0;
        state_d     = ST_ASK;
      end

      ST_ASK: begin
        presc_d = tick ? '0 : presc_q + PRESC_W'(1);
        if (tick && (secs_left_q != 6'd0)) begin
          secs_left_d = secs_left_q - 6'd1;
        end
        // Submit is tested first so it beats a coincident timeout tick.
        if (submit) begin
          correct_d = ((answer & cfg.mask) == question_q);
          state_d   = ST_JUDGE;
        end else if (tick && (secs_left_q == 6'd1)) begin
          correct_d = 1'b0;
          state_d   = ST_JUDGE;
        end
      end

      ST_JUDGE: begin
        last_correct_d = correct_q;
`ifdef QUIZ_STREAK_BONUS_EN
        if (correct_q) begin
          if (streak_q == 2'd2) begin
            bonus    = 1'b1;
            streak_d = 2'd0;
          end else begin
            streak_d = streak_q + 2'd1;
          end
        end else begin
          streak_d = 2'd0;
        end
`endif
        score_sum = {2'b00, score_q} + {2'b00, cfg.points} + {9'd0, bonus};
        if (correct_q) begin
          score_d = (score_sum > 10'd255) ? 8'hFF : score_sum[7:0];
        end
        if (q_index_q == LAST_Q) begin
          round_done_d = 1'b1;
          state_d      = ST_DONE;
        end else begin
          q_index_d = q_index_q + 4'd1;
          state_d   = ST_LOAD;
        end
      end

      ST_DONE: begin
        if ((game_state == GS_MENU) || (game_state == GS_TRY_AGAIN)) begin
          go_idle = 1'b1;
        end
      end

      default: go_idle = 1'b1;
    endcase

    // Leaving the difficulty states mid-round abandons the round.
    if (((state_q == ST_LOAD) || (state_q == ST_ASK) || (state_q == ST_JUDGE))
        && !gs_active) begin
      go_idle = 1'b1;
    end

    // IDLE shows all-zero outputs, so every entry path clears the round.
    if (go_idle) begin
      state_d        = ST_IDLE;
      question_d     = '0;
      q_index_d      = '0;
      secs_left_d    = '0;
      score_d        = '0;
      last_correct_d = 1'b0;
      round_done_d   = 1'b0;
      correct_d      = 1'b0;
      presc_d        = '0;
`ifdef QUIZ_STREAK_BONUS_EN
      streak_d       = 2'd0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      diff_q         <= DIFF_EASY;
      question_q     <= '0;
      q_index_q      <= '0;
      secs_left_q    <= '0;
      score_q        <= '0;
      last_correct_q <= 1'b0;
      round_done_q   <= 1'b0;
      correct_q      <= 1'b0;
      presc_q        <= '0;
`ifdef QUIZ_STREAK_BONUS_EN
      streak_q       <= 2'd0;
`endif
    end else begin
      state_q        <= state_d;
      diff_q         <= diff_d;
      question_q     <= question_d;
      q_index_q      <= q_index_d;
      secs_left_q    <= secs_left_d;
      score_q        <= score_d;
      last_correct_q <= last_correct_d;
      round_done_q   <= round_done_d;
      correct_q      <= correct_d;
      presc_q        <= presc_d;
`ifdef QUIZ_STREAK_BONUS_EN
      streak_q       <= streak_d;
`endif
    end
  end

  assign question     = question_q;
  assign q_index      = q_index_q;
  assign secs_left    = secs_left_q;
  assign score        = score_q;
  assign last_correct = last_correct_q;
  assign round_done   = round_done_q;

endmodule
